// File: rtl/z80fi_insn_capture.sv
// Producer side of the z80fi instruction-spec interface: assembles one record per
// retired instruction from M-cycle/T-state events and instruction-stream bytes.
module z80fi_insn_capture #(
    parameter int MAX_BYTES   = 4,
    parameter int MAX_MCYCLES = 6,
    parameter int TW          = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        cpu_ce,
    input  logic                        cyc_start,
    input  logic [2:0]                  cyc_type,
    input  logic                        insn_byte_valid,
    input  logic [7:0]                  insn_byte,
    input  logic                        insn_retire,
    input  logic [15:0]                 reg_ip,
    output logic                        z80fi_valid,
    output logic [8*MAX_BYTES-1:0]      z80fi_insn,
    output logic [2:0]                  z80fi_insn_len,
    output logic [15:0]                 z80fi_reg_ip_in,
    output logic [3*MAX_MCYCLES-1:0]    z80fi_mcycle_types,
    output logic [TW*MAX_MCYCLES-1:0]   z80fi_tcycles,
    output logic                        z80fi_overflow
);

    localparam logic [2:0] CYCLE_NONE = 3'd0;
    localparam int SW = $clog2(MAX_MCYCLES + 1);

    typedef enum logic {IDLE, CAPTURE} state_t;
    state_t state;

    logic [8*MAX_BYTES-1:0]    acc_insn, c_insn, f_insn, r_insn;
    logic [2:0]                acc_len, c_len, f_len, r_len;
    logic [3*MAX_MCYCLES-1:0]  acc_types, c_types, f_types, r_types;
    logic [TW*MAX_MCYCLES-1:0] acc_tc, c_tc, f_tc, r_tc;
    logic [SW-1:0]             acc_slot, c_slot;
    logic [TW-1:0]             acc_t, c_t;
    logic [15:0]               acc_ip, r_ip;
    logic                      acc_ovf, c_ovf, r_ovf;
    logic                      adv, take_byte, emit, load_fresh, load_cont;

    always_comb begin
        // A cyc_start coincident with retire belongs to the next instruction, so it
        // neither advances the retiring record's slot nor gives it this clk's byte.
        adv       = cyc_start && !insn_retire;
        take_byte = insn_byte_valid && !(cyc_start && insn_retire);

        c_insn  = acc_insn;
        c_len   = acc_len;
        c_types = acc_types;
        c_tc    = acc_tc;
        c_slot  = acc_slot;
        c_t     = acc_t;
        c_ovf   = acc_ovf;

        if (adv) begin
            if (acc_slot < SW'(MAX_MCYCLES))
                c_slot = acc_slot + SW'(1);
            if (c_slot < SW'(MAX_MCYCLES)) begin
                c_types[int'(c_slot)*3 +: 3] = cyc_type;
                c_tc[int'(c_slot)*TW +: TW]  = TW'(1);
            end else begin
                c_ovf = 1'b1;
            end
            c_t = TW'(1);
        end else begin
            if (acc_t != '1)
                c_t = acc_t + TW'(1);
            if (acc_slot < SW'(MAX_MCYCLES))
                c_tc[int'(acc_slot)*TW +: TW] = c_t;
        end

        if (take_byte) begin
            if (c_len < 3'(MAX_BYTES)) begin
                c_insn[int'(c_len)*8 +: 8] = insn_byte;
                c_len = c_len + 3'd1;
            end else begin
                c_ovf = 1'b1;
            end
        end

        f_insn  = '0;
        f_len   = '0;
        if (insn_byte_valid) begin
            f_insn[7:0] = insn_byte;
            f_len       = 3'd1;
        end
        f_types      = {MAX_MCYCLES{CYCLE_NONE}};
        f_types[2:0] = cyc_type;
        f_tc         = '0;
        f_tc[TW-1:0] = TW'(1);

        emit       = insn_retire && (state == CAPTURE || cyc_start);
        load_fresh = cyc_start && ((state == IDLE && !insn_retire) ||
                                   (state == CAPTURE && insn_retire));
        load_cont  = (state == CAPTURE) && !insn_retire;

        if (state == IDLE) begin
            r_insn  = f_insn;
            r_len   = f_len;
            r_types = f_types;
            r_tc    = f_tc;
            r_ip    = reg_ip;
            r_ovf   = 1'b0;
        end else begin
            r_insn  = c_insn;
            r_len   = c_len;
            r_types = c_types;
            r_tc    = c_tc;
            r_ip    = acc_ip;
            r_ovf   = c_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state              <= IDLE;
            acc_insn           <= '0;
            acc_len            <= '0;
            acc_types          <= {MAX_MCYCLES{CYCLE_NONE}};
            acc_tc             <= '0;
            acc_slot           <= '0;
            acc_t              <= '0;
            acc_ip             <= '0;
            acc_ovf            <= 1'b0;
            z80fi_valid        <= 1'b0;
            z80fi_insn         <= '0;
            z80fi_insn_len     <= '0;
            z80fi_reg_ip_in    <= '0;
            z80fi_mcycle_types <= {MAX_MCYCLES{CYCLE_NONE}};
            z80fi_tcycles      <= '0;
            z80fi_overflow     <= 1'b0;
        end else begin
            z80fi_valid <= 1'b0;
            if (cpu_ce) begin
                if (emit) begin
                    z80fi_valid        <= 1'b1;
                    z80fi_insn         <= r_insn;
                    z80fi_insn_len     <= r_len;
                    z80fi_reg_ip_in    <= r_ip;
                    z80fi_mcycle_types <= r_types;
                    z80fi_tcycles      <= r_tc;
                    z80fi_overflow     <= r_ovf;
                end
                if (load_fresh) begin
                    state     <= CAPTURE;
                    acc_insn  <= f_insn;
                    acc_len   <= f_len;
                    acc_types <= f_types;
                    acc_tc    <= f_tc;
                    acc_slot  <= '0;
                    acc_t     <= TW'(1);
                    acc_ip    <= reg_ip;
                    acc_ovf   <= 1'b0;
                end else if (load_cont) begin
                    acc_insn  <= c_insn;
                    acc_len   <= c_len;
                    acc_types <= c_types;
                    acc_tc    <= c_tc;
                    acc_slot  <= c_slot;
                    acc_t     <= c_t;
                    acc_ovf   <= c_ovf;
                end else begin
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_z80fi_insn_capture.sv
// Self-checking bench for z80fi_insn_capture: directed instruction table plus
// randomized instruction streams checked against a record-level reference model.
module tb_z80fi_insn_capture;

    localparam logic [2:0] C_M1  = 3'd1;
    localparam logic [2:0] C_MEM = 3'd2;
    localparam logic [2:0] C_IO  = 3'd3;

    logic        clk;
    logic        reset_n;
    logic        cpu_ce;
    logic        cyc_start;
    logic [2:0]  cyc_type;
    logic        insn_byte_valid;
    logic [7:0]  insn_byte;
    logic        insn_retire;
    logic [15:0] reg_ip;
    logic        z80fi_valid;
    logic [31:0] z80fi_insn;
    logic [2:0]  z80fi_insn_len;
    logic [15:0] z80fi_reg_ip_in;
    logic [17:0] z80fi_mcycle_types;
    logic [23:0] z80fi_tcycles;
    logic        z80fi_overflow;

    z80fi_insn_capture #(.MAX_BYTES(4), .MAX_MCYCLES(6), .TW(4)) dut (
        .clk(clk), .reset_n(reset_n), .cpu_ce(cpu_ce), .cyc_start(cyc_start),
        .cyc_type(cyc_type), .insn_byte_valid(insn_byte_valid), .insn_byte(insn_byte),
        .insn_retire(insn_retire), .reg_ip(reg_ip), .z80fi_valid(z80fi_valid),
        .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len),
        .z80fi_reg_ip_in(z80fi_reg_ip_in), .z80fi_mcycle_types(z80fi_mcycle_types),
        .z80fi_tcycles(z80fi_tcycles), .z80fi_overflow(z80fi_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction description: per-M-cycle type/length, byte stream, start IP.
    typedef struct packed {
        logic [15:0]      ip;
        logic [3:0]       nm;
        logic [7:0][2:0]  ty;
        logic [7:0][4:0]  tl;
        logic [3:0]       nb;
        logic [7:0][7:0]  b;
    } insn_t;

    typedef struct packed {
        logic [31:0] insn;
        logic [2:0]  len;
        logic [15:0] ip;
        logic [17:0] types;
        logic [23:0] tc;
        logic        ovf;
    } rec_t;

    typedef struct packed {
        logic [1:0]  gap;
        logic        cs;
        logic [2:0]  ty;
        logic        bv;
        logic [7:0]  b;
        logic        ret;
        logic [15:0] ip;
    } tstate_t;

    typedef struct {
        insn_t d;
        bit    ovl;
        int    gap;
        int    idle;
        rec_t  exp;
    } vec_t;

    int      ntests = 0;
    int      nfail  = 0;
    int      nvalid = 0;
    int      nexp   = 0;
    int      cyc    = 0;
    logic    rst_q  = 1'b0;
    rec_t    last   = '0;
    rec_t    expq[$];
    int      vt[$];
    tstate_t tq[$];
    vec_t    tbl[9];

    always @(posedge clk) begin
        rst_q <= reset_n;
        cyc   <= cyc + 1;
    end

    task automatic chk_rec(input string name, input rec_t e, input logic v);
        rec_t a;
        a.insn = z80fi_insn; a.len = z80fi_insn_len; a.ip = z80fi_reg_ip_in;
        a.types = z80fi_mcycle_types; a.tc = z80fi_tcycles; a.ovf = z80fi_overflow;
        ntests++;
        if (a !== e || z80fi_valid !== v) begin
            nfail++;
            $display("FAIL %s @cyc %0d: got insn=%h len=%0d ip=%h types=%h tc=%h ovf=%b valid=%b, want insn=%h len=%0d ip=%h types=%h tc=%h ovf=%b valid=%b",
                     name, cyc, a.insn, a.len, a.ip, a.types, a.tc, a.ovf, z80fi_valid,
                     e.insn, e.len, e.ip, e.types, e.tc, e.ovf, v);
        end
    endtask

    // Output monitor: every record must match the next expected one, and outputs hold between records.
    always @(negedge clk) begin
        if (!rst_q) begin
            last = '0;
            chk_rec("reset", '0, 1'b0);
        end else if (z80fi_valid) begin
            nvalid++;
            vt.push_back(cyc);
            if (expq.size() == 0) begin
                ntests++; nfail++;
                $display("FAIL unexpected_valid @cyc %0d: got valid=1 insn=%h, want no record", cyc, z80fi_insn);
            end else begin
                last = expq.pop_front();
                chk_rec("record", last, 1'b1);
            end
        end else begin
            chk_rec("hold", last, 1'b0);
        end
    end

    function automatic rec_t model(input insn_t d);
        rec_t r = '0;
        r.ip = d.ip;
        for (int k = 0; k < int'(d.nb); k++)
            if (k < 4) r.insn[8*k +: 8] = d.b[k];
        r.len = (d.nb > 4) ? 3'd4 : 3'(d.nb);
        for (int m = 0; m < int'(d.nm); m++)
            if (m < 6) begin
                r.types[3*m +: 3] = d.ty[m];
                r.tc[4*m +: 4]    = (d.tl[m] > 15) ? 4'd15 : 4'(d.tl[m]);
            end
        r.ovf = (d.nb > 4) || (d.nm > 6);
        return r;
    endfunction

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) tq.push_back('0);
    endtask

    // Byte k goes in M-cycle k mod nm at T-state 1 + k/nm (T0 for 1-T cycles).
    task automatic build(input insn_t d, input bit ovl, input int gap);
        tstate_t ts, tail;
        int tb;
        for (int m = 0; m < int'(d.nm); m++) begin
            for (int t = 0; t < int'(d.tl[m]); t++) begin
                ts     = '0;
                ts.cs  = (t == 0);
                ts.ty  = d.ty[m];
                ts.ret = (m == int'(d.nm) - 1) && (t == int'(d.tl[m]) - 1);
                ts.ip  = (m == 0 && t == 0) ? d.ip : 16'($urandom);
                for (int k = 0; k < int'(d.nb); k++) begin
                    tb = (d.tl[m] == 1) ? 0 : 1 + k / int'(d.nm);
                    if (k % int'(d.nm) == m && tb == t) begin
                        ts.bv = 1'b1;
                        ts.b  = d.b[k];
                    end
                end
                ts.gap = (gap == 2) ? 2'($urandom_range(0, 2)) : 2'(gap);
                if (m == 0 && t == 0 && ovl && tq.size() > 0) begin
                    tail    = tq.pop_back();
                    tail.cs = 1'b1;
                    tail.ty = ts.ty;
                    tail.ip = ts.ip;
                    tq.push_back(tail);
                end else begin
                    tq.push_back(ts);
                end
            end
        end
    endtask

    task automatic set_idle;
        cpu_ce = 1'b1; cyc_start = 1'b0; cyc_type = '0; insn_byte_valid = 1'b0;
        insn_byte = '0; insn_retire = 1'b0; reg_ip = '0;
    endtask

    task automatic play(input int n);
        tstate_t ts;
        for (int i = 0; i < n && i < tq.size(); i++) begin
            ts = tq[i];
            for (int g = 0; g < int'(ts.gap); g++) begin
                cpu_ce = 1'b0;
                cyc_start = 1'($urandom); insn_retire = 1'($urandom);
                insn_byte_valid = 1'($urandom); insn_byte = 8'($urandom);
                cyc_type = 3'($urandom); reg_ip = 16'($urandom);
                @(posedge clk); #1;
            end
            cpu_ce = 1'b1; cyc_start = ts.cs; cyc_type = ts.ty; insn_byte_valid = ts.bv;
            insn_byte = ts.b; insn_retire = ts.ret; reg_ip = ts.ip;
            @(posedge clk); #1;
        end
        set_idle();
        tq.delete();
    endtask

    task automatic idle_clks(input int n);
        set_idle();
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        insn_t d;
        bit    ovl;
        int    gsel;

        // LD IX,nn
        tbl[0].d = '{ip:16'h0100, nm:4'd4, ty:{12'd0, C_MEM, C_MEM, C_M1, C_M1},
                     tl:{20'd0, 5'd3, 5'd3, 5'd4, 5'd4}, nb:4'd4, b:64'h00000000_123421DD};
        tbl[0].ovl = 0; tbl[0].gap = 0; tbl[0].idle = 2;
        tbl[0].exp = '{insn:32'h123421DD, len:3'd4, ip:16'h0100,
                       types:{3'd0, 3'd0, C_MEM, C_MEM, C_M1, C_M1},
                       tc:{4'd0, 4'd0, 4'd3, 4'd3, 4'd4, 4'd4}, ovf:1'b0};
        // NOP followed immediately by NOP
        tbl[1].d = '{ip:16'h0200, nm:4'd1, ty:{21'd0, C_M1}, tl:{35'd0, 5'd4}, nb:4'd1, b:64'h0};
        tbl[1].ovl = 0; tbl[1].gap = 0; tbl[1].idle = 2;
        tbl[1].exp = '{insn:32'h0, len:3'd1, ip:16'h0200, types:{15'd0, C_M1}, tc:{20'd0, 4'd4}, ovf:1'b0};
        tbl[2].d = '{ip:16'h0201, nm:4'd1, ty:{21'd0, C_M1}, tl:{35'd0, 5'd4}, nb:4'd1, b:64'h0};
        tbl[2].ovl = 0; tbl[2].gap = 0; tbl[2].idle = 0;
        tbl[2].exp = '{insn:32'h0, len:3'd1, ip:16'h0201, types:{15'd0, C_M1}, tc:{20'd0, 4'd4}, ovf:1'b0};
        // LD IX,nn with cpu_ce low every other clk
        tbl[3] = tbl[0]; tbl[3].gap = 1;
        // Six bytes over seven M-cycles
        tbl[4].d = '{ip:16'h3000, nm:4'd7, ty:{3'd0, C_MEM, C_MEM, C_IO, C_MEM, C_MEM, C_MEM, C_M1},
                     tl:{5'd0, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3}, nb:4'd6, b:64'h00000605_04030201};
        tbl[4].ovl = 0; tbl[4].gap = 0; tbl[4].idle = 2;
        tbl[4].exp = '{insn:32'h04030201, len:3'd4, ip:16'h3000,
                       types:{C_MEM, C_IO, C_MEM, C_MEM, C_MEM, C_M1}, tc:{6{4'd3}}, ovf:1'b1};
        // One-T single M-cycle: start and retire in the same clk
        tbl[5].d = '{ip:16'h4444, nm:4'd1, ty:{21'd0, C_M1}, tl:{35'd0, 5'd1}, nb:4'd1, b:64'hAB};
        tbl[5].ovl = 0; tbl[5].gap = 0; tbl[5].idle = 2;
        tbl[5].exp = '{insn:32'hAB, len:3'd1, ip:16'h4444, types:{15'd0, C_M1}, tc:{20'd0, 4'd1}, ovf:1'b0};
        // LD A,n whose retire coincides with the next cyc_start (INC A)
        tbl[6].d = '{ip:16'h5000, nm:4'd2, ty:{18'd0, C_MEM, C_M1}, tl:{30'd0, 5'd3, 5'd4}, nb:4'd2, b:64'h553E};
        tbl[6].ovl = 0; tbl[6].gap = 0; tbl[6].idle = 2;
        tbl[6].exp = '{insn:32'h553E, len:3'd2, ip:16'h5000, types:{12'd0, C_MEM, C_M1},
                       tc:{16'd0, 4'd3, 4'd4}, ovf:1'b0};
        tbl[7].d = '{ip:16'h5002, nm:4'd1, ty:{21'd0, C_M1}, tl:{35'd0, 5'd4}, nb:4'd1, b:64'h3C};
        tbl[7].ovl = 1; tbl[7].gap = 0; tbl[7].idle = 0;
        tbl[7].exp = '{insn:32'h3C, len:3'd1, ip:16'h5002, types:{15'd0, C_M1}, tc:{20'd0, 4'd4}, ovf:1'b0};
        // T-state count saturation
        tbl[8].d = '{ip:16'h6000, nm:4'd1, ty:{21'd0, C_M1}, tl:{35'd0, 5'd20}, nb:4'd1, b:64'h76};
        tbl[8].ovl = 0; tbl[8].gap = 0; tbl[8].idle = 2;
        tbl[8].exp = '{insn:32'h76, len:3'd1, ip:16'h6000, types:{15'd0, C_M1}, tc:{20'd0, 4'd15}, ovf:1'b0};

        reset_n = 1'b0;
        set_idle();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        idle_clks(2);

        for (int i = 0; i < 9; i++) begin
            push_idle(tbl[i].idle);
            build(tbl[i].d, tbl[i].ovl, tbl[i].gap);
            expq.push_back(tbl[i].exp);
            nexp++;
        end
        play(tq.size());
        idle_clks(5);

        ntests++;
        if (vt.size() < 3 || vt[2] - vt[1] != 4) begin
            nfail++;
            $display("FAIL nop_spacing: got %0d valid pulses, gap %0d clks, want gap 4",
                     vt.size(), (vt.size() >= 3) ? vt[2] - vt[1] : -1);
        end

        // Bytes and retires without a cyc_start while idle must not produce a record.
        for (int i = 0; i < 20; i++) begin
            cpu_ce = 1'b1; cyc_start = 1'b0;
            insn_byte_valid = 1'($urandom); insn_byte = 8'($urandom);
            insn_retire = 1'($urandom); reg_ip = 16'($urandom);
            @(posedge clk); #1;
        end
        idle_clks(3);

        // Abort LD IX,nn in its third M-cycle, then a NOP.
        build(tbl[0].d, 1'b0, 0);
        play(10);
        reset_n = 1'b0;
        idle_clks(2);
        reset_n = 1'b1;
        idle_clks(1);
        build(tbl[1].d, 1'b0, 0);
        expq.push_back(tbl[1].exp);
        nexp++;
        play(tq.size());
        idle_clks(5);

        // Randomized instruction stream against the reference model.
        for (int i = 0; i < 60; i++) begin
            d    = '0;
            d.ip = 16'($urandom);
            d.nm = 4'($urandom_range(1, 8));
            for (int m = 0; m < int'(d.nm); m++) begin
                d.ty[m] = 3'($urandom_range(1, 7));
                d.tl[m] = (m == int'(d.nm) - 1) ? 5'($urandom_range(3, 6)) : 5'($urandom_range(2, 5));
                if ($urandom_range(0, 9) == 0) d.tl[m] = 5'($urandom_range(14, 20));
            end
            d.nb = 4'($urandom_range(0, int'(d.nm)));
            for (int k = 0; k < 8; k++) d.b[k] = 8'($urandom);
            ovl  = (i > 0) && ($urandom_range(0, 2) == 0);
            gsel = ($urandom_range(0, 1) == 0) ? 0 : 2;
            if (!ovl) push_idle($urandom_range(0, 2));
            build(d, ovl, gsel);
            expq.push_back(model(d));
            nexp++;
        end
        play(tq.size());
        idle_clks(6);

        ntests++;
        if (expq.size() != 0 || nvalid != nexp) begin
            nfail++;
            $display("FAIL record_count: got %0d records (%0d still expected), want %0d",
                     nvalid, expq.size(), nexp);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
